// File: rtl/gemm_tile_scheduler_if.sv
// Host/array-controller bundle for the GEMM tile scheduler.
// slave = scheduler side, master = host/testbench side.
interface gemm_tile_scheduler_if #(
  parameter int LOG2_SRAM_BANK_DEPTH = 10,
  parameter int CTRL_WIDTH           = 4,
  parameter int TILE_CNT_WIDTH       = 8
);
  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int TW = TILE_CNT_WIDTH;

  logic                  i_start;
  logic [AW-1:0]         i_k_len;
  logic [TW-1:0]         i_num_m_tiles;
  logic [TW-1:0]         i_num_n_tiles;
  logic [AW-1:0]         i_top_base_addr;
  logic [AW-1:0]         i_left_base_addr;
  logic                  i_sa_valid_down_last;
  logic [CTRL_WIDTH-1:0] o_ctrl_state;
  logic [AW-1:0]         o_top_rd_start_addr;
  logic [AW-1:0]         o_top_rd_end_addr;
  logic [AW-1:0]         o_left_rd_start_addr;
  logic [AW-1:0]         o_left_rd_end_addr;
  logic [TW-1:0]         o_tile_m_idx;
  logic [TW-1:0]         o_tile_n_idx;
  logic                  o_sa_clear;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;

  modport slave (
    input  i_start, i_k_len,
    input  i_num_m_tiles, i_num_n_tiles,
    input  i_top_base_addr, i_left_base_addr,
    input  i_sa_valid_down_last,
    output o_ctrl_state,
    output o_top_rd_start_addr, o_top_rd_end_addr,
    output o_left_rd_start_addr, o_left_rd_end_addr,
    output o_tile_m_idx, o_tile_n_idx,
    output o_sa_clear, o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_k_len,
    output i_num_m_tiles, i_num_n_tiles,
    output i_top_base_addr, i_left_base_addr,
    output i_sa_valid_down_last,
    input  o_ctrl_state,
    input  o_top_rd_start_addr, o_top_rd_end_addr,
    input  o_left_rd_start_addr, o_left_rd_end_addr,
    input  o_tile_m_idx, o_tile_n_idx,
    input  o_sa_clear, o_busy, o_done, o_error
  );
endinterface

// File: rtl/gemm_tile_scheduler.sv
// Output-stationary systolic array sequencer: walks MxN output
// tiles, drives controller state code and SRAM read windows.
module gemm_tile_scheduler #(
  parameter int NUM_ROW              = 8,
  parameter int NUM_COL              = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 10,
  parameter int CTRL_WIDTH           = 4,
  parameter int TILE_CNT_WIDTH       = 8,
  parameter int DRAIN_TIMEOUT        = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gemm_tile_scheduler_if.slave  bus
);
  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int TW = TILE_CNT_WIDTH;
  localparam int PW = AW + TW;
  localparam int SW = AW + 2;
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int BW = $clog2(NUM_ROW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STEADY,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] tbase_q, tbase_d;
  logic [AW-1:0] lbase_q, lbase_d;
  logic [TW-1:0] num_m_q, num_m_d;
  logic [TW-1:0] num_n_q, num_n_d;
  logic [TW-1:0] m_q, m_d;
  logic [TW-1:0] n_q, n_d;
  logic [SW-1:0] cyc_q, cyc_d;
  logic [DW-1:0] dcyc_q, dcyc_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          err_q, err_d;
  logic [AW-1:0] ts_q, ts_d;
  logic [AW-1:0] te_q, te_d;
  logic [AW-1:0] ls_q, ls_d;
  logic [AW-1:0] le_q, le_d;

  logic [SW-1:0] steady_len;
  logic [BW-1:0] beats_nxt;
  logic          n_wrap;
  logic          last_tile;
  logic          zero_job;
  logic          load_addr;
  logic [AW-1:0] a_k, a_tb, a_lb;
  logic [TW-1:0] a_m, a_n;

  assign steady_len = SW'(k_q) + SW'(NUM_ROW + NUM_COL - 2);
  assign beats_nxt  = beat_q + BW'(bus.i_sa_valid_down_last);
  assign n_wrap     = (n_q == num_n_q - TW'(1));
  assign last_tile  = n_wrap && (m_q == num_m_q - TW'(1));
  assign zero_job   = (bus.i_k_len == '0) ||
                      (bus.i_num_m_tiles == '0) ||
                      (bus.i_num_n_tiles == '0);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    tbase_d   = tbase_q;
    lbase_d   = lbase_q;
    num_m_d   = num_m_q;
    num_n_d   = num_n_q;
    m_d       = m_q;
    n_d       = n_q;
    cyc_d     = cyc_q;
    dcyc_d    = dcyc_q;
    beat_d    = beat_q;
    err_d     = err_q;
    ts_d      = ts_q;
    te_d      = te_q;
    ls_d      = ls_q;
    le_d      = le_q;
    load_addr = 1'b0;
    a_k       = k_q;
    a_tb      = tbase_q;
    a_lb      = lbase_q;
    a_m       = m_q;
    a_n       = n_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          k_d     = bus.i_k_len;
          tbase_d = bus.i_top_base_addr;
          lbase_d = bus.i_left_base_addr;
          num_m_d = bus.i_num_m_tiles;
          num_n_d = bus.i_num_n_tiles;
          m_d     = '0;
          n_d     = '0;
          err_d   = 1'b0;
          if (zero_job) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_CLEAR;
            load_addr = 1'b1;
            a_k       = bus.i_k_len;
            a_tb      = bus.i_top_base_addr;
            a_lb      = bus.i_left_base_addr;
            a_m       = '0;
            a_n       = '0;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_STEADY;
        cyc_d   = '0;
      end
      S_STEADY: begin
        if (cyc_q == steady_len - SW'(1)) begin
          state_d = S_DRAIN;
          cyc_d   = '0;
          dcyc_d  = '0;
          beat_d  = '0;
        end else begin
          cyc_d = cyc_q + SW'(1);
        end
      end
      S_DRAIN: begin
        beat_d = beats_nxt;
        dcyc_d = dcyc_q + DW'(1);
        if (beats_nxt == BW'(NUM_ROW)) begin
          state_d = S_NEXT;
        end else if (dcyc_q == DW'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_tile) begin
          state_d = S_DONE;
        end else begin
          n_d       = n_wrap ? '0 : n_q + TW'(1);
          m_d       = n_wrap ? m_q + TW'(1) : m_q;
          a_m       = m_d;
          a_n       = n_d;
          load_addr = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Full-width product, wrapped into the bank address space
    if (load_addr) begin
      ts_d = AW'(PW'(a_tb) + PW'(a_n) * PW'(a_k));
      te_d = ts_d + a_k;
      ls_d = AW'(PW'(a_lb) + PW'(a_m) * PW'(a_k));
      le_d = ls_d + a_k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      tbase_q <= '0;
      lbase_q <= '0;
      num_m_q <= '0;
      num_n_q <= '0;
      m_q     <= '0;
      n_q     <= '0;
      cyc_q   <= '0;
      dcyc_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      ts_q    <= '0;
      te_q    <= '0;
      ls_q    <= '0;
      le_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tbase_q <= tbase_d;
      lbase_q <= lbase_d;
      num_m_q <= num_m_d;
      num_n_q <= num_n_d;
      m_q     <= m_d;
      n_q     <= n_d;
      cyc_q   <= cyc_d;
      dcyc_q  <= dcyc_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      ts_q    <= ts_d;
      te_q    <= te_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
    end
  end

  assign bus.o_ctrl_state =
    (state_q == S_STEADY) ? CTRL_WIDTH'(1) :
    (state_q == S_DRAIN)  ? CTRL_WIDTH'(3) : '0;

  assign bus.o_top_rd_start_addr  = ts_q;
  assign bus.o_top_rd_end_addr    = te_q;
  assign bus.o_left_rd_start_addr = ls_q;
  assign bus.o_left_rd_end_addr   = le_q;
  assign bus.o_tile_m_idx         = m_q;
  assign bus.o_tile_n_idx         = n_q;
  assign bus.o_sa_clear           = (state_q == S_CLEAR);
  assign bus.o_done               = (state_q == S_DONE);
  assign bus.o_error              = err_q;

  // Busy covers the accepting cycle and drops as done pulses
  assign bus.o_busy =
    (state_q != S_IDLE && state_q != S_DONE) ||
    (state_q == S_IDLE && bus.i_start && rst_n);
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: tile order, windows,
// cycle counts, zero-size jobs, dropped starts, reset, timeout.
module tb_gemm_tile_scheduler;
  localparam int AW = 10;
  localparam int TW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gemm_tile_scheduler_if #(
    .LOG2_SRAM_BANK_DEPTH(AW),
    .CTRL_WIDTH(CW),
    .TILE_CNT_WIDTH(TW)
  ) bus ();

  gemm_tile_scheduler #(
    .NUM_ROW(8),
    .NUM_COL(8),
    .LOG2_SRAM_BANK_DEPTH(AW),
    .CTRL_WIDTH(CW),
    .TILE_CNT_WIDTH(TW),
    .DRAIN_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_err = 0;
  int n_chk = 0;

  int clr_n, done_n, done_cyc, busy_n;
  int err_done, err_c1;
  int st_len[$];
  int dr_len[$];
  int tm[$];
  int tn[$];
  int ts[$];
  int te[$];
  int ls[$];
  int le[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid always 1; 1: every other drain cycle; 2: never
  task automatic job(input int k, input int nm, input int nn,
                     input int tb, input int lb,
                     input int mode, input bit inject);
    int st_cur, dr_cur;
    logic [CW-1:0] prev, cs;
    tick();
    clr_n = 0; done_n = 0; done_cyc = -1; busy_n = 0;
    err_done = -1; err_c1 = -1;
    st_len.delete(); dr_len.delete();
    tm.delete(); tn.delete();
    ts.delete(); te.delete(); ls.delete(); le.delete();
    bus.i_k_len          = AW'(k);
    bus.i_num_m_tiles    = TW'(nm);
    bus.i_num_n_tiles    = TW'(nn);
    bus.i_top_base_addr  = AW'(tb);
    bus.i_left_base_addr = AW'(lb);
    bus.i_start          = 1'b1;
    #1;
    busy_n += int'(bus.o_busy);
    tick();
    bus.i_start = 1'b0;
    prev = '0; st_cur = 0; dr_cur = 0;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      cs = bus.o_ctrl_state;
      if (cyc == 1) err_c1 = int'(bus.o_error);
      if (cs == 1) st_cur++;
      else if (prev == 1) begin
        st_len.push_back(st_cur); st_cur = 0;
      end
      if (cs == 3) dr_cur++;
      else if (prev == 3) begin
        dr_len.push_back(dr_cur); dr_cur = 0;
      end
      prev = cs;
      if (bus.o_sa_clear) begin
        clr_n++;
        tm.push_back(int'(bus.o_tile_m_idx));
        tn.push_back(int'(bus.o_tile_n_idx));
        ts.push_back(int'(bus.o_top_rd_start_addr));
        te.push_back(int'(bus.o_top_rd_end_addr));
        ls.push_back(int'(bus.o_left_rd_start_addr));
        le.push_back(int'(bus.o_left_rd_end_addr));
      end
      busy_n += int'(bus.o_busy);
      case (mode)
        0: bus.i_sa_valid_down_last = 1'b1;
        1: bus.i_sa_valid_down_last = (cs == 3) && (dr_cur % 2 == 1);
        default: bus.i_sa_valid_down_last = 1'b0;
      endcase
      if (inject && cs == 1 && st_cur == 5) begin
        bus.i_start         = 1'b1;
        bus.i_k_len         = AW'(k + 3);
        bus.i_num_n_tiles   = TW'(nn + 2);
        bus.i_top_base_addr = AW'(tb + 7);
      end else begin
        bus.i_start = 1'b0;
      end
      if (bus.o_done) begin
        done_n++;
        done_cyc = cyc;
        err_done = int'(bus.o_error);
        break;
      end
      tick();
    end
    chk("done_seen", done_cyc > 0, 1);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_k_len = '0;
    bus.i_num_m_tiles = '0;
    bus.i_num_n_tiles = '0;
    bus.i_top_base_addr = '0;
    bus.i_left_base_addr = '0;
    bus.i_sa_valid_down_last = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl", bus.o_ctrl_state, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_error, 0);
    chk("rst_clr", bus.o_sa_clear, 0);
    chk("rst_ts", bus.o_top_rd_start_addr, 0);
    rst_n = 1'b1;

    // 8x8, K=4, single tile
    job(4, 1, 1, 0, 0, 0, 1'b0);
    chk("t1_clr", clr_n, 1);
    chk("t1_st_n", st_len.size(), 1);
    if (st_len.size() == 1) chk("t1_st", st_len[0], 18);
    if (dr_len.size() == 1) chk("t1_dr", dr_len[0], 8);
    chk("t1_done_cyc", done_cyc, 29);
    chk("t1_busy", busy_n, 29);
    if (clr_n == 1) begin
      chk("t1_ts", ts[0], 0);
      chk("t1_te", te[0], 4);
      chk("t1_ls", ls[0], 0);
      chk("t1_le", le[0], 4);
    end
    chk("t1_err", err_done, 0);

    // K=16, 2x3 tiles, bases 100/200, gappy drain
    job(16, 2, 3, 100, 200, 1, 1'b0);
    chk("t2_clr", clr_n, 6);
    chk("t2_st_n", st_len.size(), 6);
    chk("t2_dr_n", dr_len.size(), 6);
    chk("t2_done_cyc", done_cyc, 283);
    chk("t2_done_n", done_n, 1);
    for (int i = 0; i < clr_n && i < 6; i++) begin
      chk("t2_m", tm[i], i / 3);
      chk("t2_n", tn[i], i % 3);
      chk("t2_ts", ts[i], 100 + 16 * (i % 3));
      chk("t2_te", te[i], 116 + 16 * (i % 3));
      chk("t2_ls", ls[i], 200 + 16 * (i / 3));
      chk("t2_le", le[i], 216 + 16 * (i / 3));
    end
    for (int i = 0; i < st_len.size(); i++)
      chk("t2_st", st_len[i], 30);
    for (int i = 0; i < dr_len.size(); i++)
      chk("t2_dr", dr_len[i], 15);

    // zero-size jobs
    job(4, 1, 0, 0, 0, 0, 1'b0);
    chk("z_n_done_cyc", done_cyc, 1);
    chk("z_n_busy", busy_n, 1);
    chk("z_n_steady", st_len.size(), 0);
    chk("z_n_clr", clr_n, 0);
    job(0, 2, 2, 0, 0, 0, 1'b0);
    chk("z_k_done_cyc", done_cyc, 1);
    chk("z_k_busy", busy_n, 1);
    chk("z_k_steady", st_len.size(), 0);

    // start during STEADY and during DONE is dropped
    job(4, 1, 2, 0, 0, 0, 1'b1);
    chk("t4_clr", clr_n, 2);
    chk("t4_done_cyc", done_cyc, 57);
    chk("t4_done_n", done_n, 1);
    if (clr_n == 2) begin
      chk("t4_ts1", ts[1], 4);
      chk("t4_n1", tn[1], 1);
    end
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    #1;
    chk("t4_done_start_busy", bus.o_busy, 0);
    chk("t4_done_start_clr", bus.o_sa_clear, 0);

    // reset mid-STEADY
    tick();
    bus.i_k_len = 10'd4;
    bus.i_num_m_tiles = 8'd1;
    bus.i_num_n_tiles = 8'd1;
    bus.i_top_base_addr = 10'd100;
    bus.i_left_base_addr = 10'd200;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (5) tick();
    chk("r_pre_state", bus.o_ctrl_state, 1);
    rst_n = 1'b0;
    #1;
    chk("r_ctrl", bus.o_ctrl_state, 0);
    chk("r_busy", bus.o_busy, 0);
    chk("r_ts", bus.o_top_rd_start_addr, 0);
    chk("r_le", bus.o_left_rd_end_addr, 0);
    tick();
    rst_n = 1'b1;
    job(4, 1, 1, 0, 0, 0, 1'b0);
    chk("r_done_cyc", done_cyc, 29);
    chk("r_clr", clr_n, 1);

    // drain timeout
    job(4, 1, 1, 0, 0, 2, 1'b0);
    if (dr_len.size() == 1) chk("to_dr", dr_len[0], 64);
    chk("to_done_cyc", done_cyc, 85);
    chk("to_err_done", err_done, 1);
    tick();
    chk("to_err_sticky", bus.o_error, 1);

    // address wrap; next start clears error
    job(8, 1, 2, 1020, 0, 0, 1'b0);
    chk("w_err_c1", err_c1, 0);
    chk("w_err_done", err_done, 0);
    chk("w_clr", clr_n, 2);
    if (clr_n == 2) begin
      chk("w_ts0", ts[0], 1020);
      chk("w_te0", te[0], 4);
      chk("w_ts1", ts[1], 4);
      chk("w_te1", te[1], 12);
      chk("w_le1", le[1], 8);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/gemm_tile_scheduler.md
Name: gemm_tile_scheduler

Overview:
- Top-level sequencer for the output-stationary systolic array.
- Drives the array controller's 4-bit state code: IDLE=0, STEADY=1, DRAIN=3.
- Drives the controller's top/left SRAM read-window addresses per output tile.
- Loops over M×N output tiles, counts steady/skew cycles and drain-valid beats, and handshakes with the host via start/busy/done.

Parameters:
NUM_ROW, 8, array rows
NUM_COL, 8, array columns
LOG2_SRAM_BANK_DEPTH, 10, SRAM address width
CTRL_WIDTH, 4, controller state-code width
TILE_CNT_WIDTH, 8, width of tile counts/indices
DRAIN_TIMEOUT, 64, max DRAIN cycles before forced exit

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  start pulse; ignored while o_busy=1
i_k_len  in  LOG2_SRAM_BANK_DEPTH  reduction length K (SRAM rows per tile)
i_num_m_tiles  in  TILE_CNT_WIDTH  tile count along rows (left operand)
i_num_n_tiles  in  TILE_CNT_WIDTH  tile count along columns (top operand)
i_top_base_addr  in  LOG2_SRAM_BANK_DEPTH  top SRAM base address
i_left_base_addr  in  LOG2_SRAM_BANK_DEPTH  left SRAM base address
i_sa_valid_down_last  in  1  valid_down of last array column
o_ctrl_state  out  CTRL_WIDTH  state code to array controller
o_top_rd_start_addr / o_top_rd_end_addr  out  LOG2_SRAM_BANK_DEPTH  top read window
o_left_rd_start_addr / o_left_rd_end_addr  out  LOG2_SRAM_BANK_DEPTH  left read window
o_tile_m_idx / o_tile_n_idx  out  TILE_CNT_WIDTH  current tile indices
o_sa_clear  out  1  one-cycle accumulator clear per tile
o_busy  out  1  high from accepted start until done
o_done  out  1  one-cycle completion pulse
o_error  out  1  sticky drain-timeout flag; cleared on next accepted start

Behaviour:
- Reset values: all outputs 0 (o_ctrl_state=0). FSM goes to S_IDLE; counters and latched config are 0.
- Reset mid-operation aborts immediately. Outputs show reset values in the same cycle rst_n falls.
- Config is latched on the accepted start. Later input changes are ignored until the next start.
- FSM states:
  - S_IDLE (code 0): on i_start, latch config, set o_busy=1, clear o_error. If K=0 or either tile count is 0, go to S_DONE; otherwise go to S_CLEAR with m_idx=n_idx=0.
  - S_CLEAR (code 0): o_sa_clear=1 for exactly 1 cycle; read-window outputs are already valid here. Next state S_STEADY.
  - S_STEADY (code 1): stay exactly STEADY_LEN = K + NUM_ROW + NUM_COL − 2 cycles (cycle counter), then go to S_DRAIN.
  - S_DRAIN (code 3): count cycles where i_sa_valid_down_last=1.
    - When the count reaches NUM_ROW, go to S_NEXT.
    - If DRAIN_TIMEOUT cycles elapse first, set o_error=1 and go to S_NEXT anyway.
  - S_NEXT (code 0, 1 cycle): n_idx++; on n wrap (n_idx==num_n−1) set n_idx=0 and m_idx++ (n is the inner loop).
    - If the last tile (m_idx==num_m−1 and n_idx==num_n−1) just finished, go to S_DONE; otherwise go to S_CLEAR.
  - S_DONE (code 0): o_done=1 for 1 cycle, o_busy=0, then go to S_IDLE.
- Address arithmetic, registered, updated on the edge entering S_CLEAR:
  - top_start = top_base + n_idx·K; top_end = top_start + K.
  - left_start = left_base + m_idx·K; left_end = left_start + K.
  - All results wrap modulo 2^LOG2_SRAM_BANK_DEPTH. Product is computed at full width, then truncated.
- Latency:
  - Start accepted at edge t: S_CLEAR during cycle t+1, STEADY from t+2.
  - Per-tile cost = 1 + STEADY_LEN + drain cycles + 1.
  - Zero-size start: o_done at cycle t+1, no STEADY ever issued.
- o_tile_m_idx / o_tile_n_idx reflect the tile currently in CLEAR/STEADY/DRAIN.
- i_start while busy is dropped, with no queueing. i_start in the same cycle as S_DONE is also ignored.

Test Plan:
- 8×8 array, K=4, 1×1 tiles, bases 0/0 → o_ctrl_state sequence 0(clear)→1 for 18 cycles→3 until 8 valid beats→0.
  - Windows top 0..4, left 0..4; o_done 1 cycle later; o_sa_clear pulsed once.
- K=16, 2×3 tiles, top_base=100, left_base=200 → 6 tiles in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - top_start 100/116/132 repeated; left_start 200 for m=0, 216 for m=1; six o_sa_clear pulses; one o_done.
- num_n_tiles=0 (and separately K=0) → o_done one cycle after start; o_ctrl_state never 1; o_busy high exactly 1 cycle.
- Second i_start during STEADY → ignored; tile sequence and o_done count unchanged.
- rst_n deasserted mid-STEADY → outputs 0 immediately.
  - Fresh start after release runs a full correct sequence.
- i_sa_valid_down_last held 0 in DRAIN → exit after 64 cycles, o_error=1 sticky through o_done; next start clears it.
- top_base=1020, K=8, n_idx=1 → top_start=(1020+8) mod 1024=4, top_end=12.
